rr_stream_arbiter: RTL and testbench

//  Packet-aware round-robin arbiter sharing one valid/ready stream channel among NUM_REQ

---
 rtl/rr_stream_arbiter_if.sv | 29 ++
 rtl/rr_stream_arbiter.sv | 97 +++++++++
 tb/tb_rr_stream_arbiter.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/rr_stream_arbiter_if.sv
// rtl/rr_stream_arbiter_if.sv - requester/consumer stream bundle for the round-robin arbiter
// master = arbiter view, slave = producers/consumer view.
interface rr_stream_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]                 req_valid_i;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_data_i;
  logic [NUM_REQ-1:0]                 req_last_i;
  logic [NUM_REQ-1:0]                 req_ready_o;
  logic                               out_valid_o;
  logic [DATA_WIDTH-1:0]              out_data_o;
  logic                               out_last_o;
  logic                               out_ready_i;
  logic [IW-1:0]                      out_src_o;
  logic                               busy_o;

  modport master (
    input  req_valid_i, req_data_i, req_last_i, out_ready_i,
    output req_ready_o, out_valid_o, out_data_o, out_last_o, out_src_o, busy_o
  );

  modport slave (
    output req_valid_i, req_data_i, req_last_i, out_ready_i,
    input  req_ready_o, out_valid_o, out_data_o, out_last_o, out_src_o, busy_o
  );
endinterface

// File: rtl/rr_stream_arbiter.sv
// rtl/rr_stream_arbiter.sv - packet-aware round-robin arbiter onto one valid/ready stream
// Grant is frozen from first offered beat until the last beat handshakes.
module rr_stream_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                 clk_i,
  input  logic                 arst_i,
  rr_stream_arbiter_if.master  bus
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] sel_q, sel_d;
  logic [IW-1:0] cand;
  logic [IW-1:0] scan_idx;
  logic [IW-1:0] act;
  logic          any_valid;
  logic          out_valid;
  logic          hs;

  function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] i);
    return (i == IW'(NUM_REQ - 1)) ? '0 : i + IW'(1);
  endfunction

  // Scan downwards so the lowest rotation offset from ptr wins.
  always_comb begin
    cand      = '0;
    any_valid = 1'b0;
    scan_idx  = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      scan_idx = IW'((int'(ptr_q) + k) % NUM_REQ);
      if (bus.req_valid_i[scan_idx]) begin
        cand      = scan_idx;
        any_valid = 1'b1;
      end
    end
  end

  always_comb begin
    act             = (state_q == LOCKED) ? sel_q : cand;
    out_valid       = ~arst_i & bus.req_valid_i[act] & ((state_q == LOCKED) | any_valid);
    hs              = out_valid & bus.out_ready_i;
    bus.out_valid_o = out_valid;
    bus.out_data_o  = bus.req_data_i[act];
    bus.out_last_o  = bus.req_last_i[act];
    bus.out_src_o   = arst_i ? '0 : act;
    bus.busy_o      = ~arst_i & (state_q == LOCKED);
    bus.req_ready_o = '0;
    if (!arst_i && ((state_q == LOCKED) || any_valid)) begin
      bus.req_ready_o[act] = bus.out_ready_i;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    unique case (state_q)
      IDLE: begin
        if (any_valid) begin
          if (hs && bus.out_last_o) begin
            ptr_d = wrap_inc(cand);
          end else begin
            state_d = LOCKED;
            sel_d   = cand;
          end
        end
      end
      LOCKED: begin
        if (hs && bus.out_last_o) begin
          state_d = IDLE;
          ptr_d   = wrap_inc(sel_q);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
    end
  end
endmodule

// File: tb/tb_rr_stream_arbiter.sv
// tb/tb_rr_stream_arbiter.sv - bench for rr_stream_arbiter: directed cases then random run
// Reference keeps an owner index and a next-priority index per the arbitration rules.
module tb_rr_stream_arbiter;
  localparam int N  = 4;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  rr_stream_arbiter_if #(.NUM_REQ(N), .DATA_WIDTH(DW)) bus ();

  rr_stream_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW)) dut (
    .clk_i  (clk),
    .arst_i (rst),
    .bus    (bus.master)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int m_owner = -1;
  int m_ptr   = 0;

  logic          s_valid, s_last, s_hs, s_busy;
  logic [DW-1:0] s_data;
  logic [N-1:0]  s_ready;
  int            s_src;

  logic [8:0] sbq[N][$];
  int         left_beats[N];
  int         wait_pk[N];
  int         open_src = -1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_act();
    if (m_owner >= 0) return m_owner;
    for (int k = 0; k < N; k++) begin
      if (bus.req_valid_i[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic drive(input int i, input logic v, input logic [DW-1:0] d, input logic l);
    bus.req_valid_i[i] = v;
    bus.req_data_i[i]  = d;
    bus.req_last_i[i]  = l;
  endtask

  // Check combinational outputs mid-cycle, advance the reference, return just past the edge.
  task automatic tick();
    int a;
    logic [N-1:0] er;
    logic ev;
    @(negedge clk);
    s_valid = bus.out_valid_o;
    s_last  = bus.out_last_o;
    s_data  = bus.out_data_o;
    s_ready = bus.req_ready_o;
    s_busy  = bus.busy_o;
    s_src   = int'(bus.out_src_o);
    s_hs    = s_valid & bus.out_ready_i;
    if (rst) begin
      chk("rst_valid", 32'(s_valid), 0);
      chk("rst_ready", 32'(s_ready), 0);
      chk("rst_busy", 32'(s_busy), 0);
      chk("rst_src", 32'(s_src), 0);
      m_owner = -1;
      m_ptr   = 0;
    end else begin
      a  = exp_act();
      er = '0;
      ev = 1'b0;
      if (a >= 0) begin
        er[a] = bus.out_ready_i;
        ev    = bus.req_valid_i[a];
      end
      chk("ready", 32'(s_ready), 32'(er));
      chk("busy", 32'(s_busy), (m_owner >= 0) ? 1 : 0);
      chk("valid", 32'(s_valid), 32'(ev));
      if (a >= 0) begin
        chk("src", 32'(s_src), 32'(a));
        if (ev) begin
          chk("data", 32'(s_data), 32'(bus.req_data_i[a]));
          chk("last", 32'(s_last), 32'(bus.req_last_i[a]));
        end
        if (ev && bus.out_ready_i && bus.req_last_i[a]) begin
          m_owner = -1;
          m_ptr   = (a + 1) % N;
        end else begin
          m_owner = a;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [DW-1:0] d;
    logic          l;
    logic [8:0]    exp_beat;

    bus.req_valid_i = '0;
    bus.req_data_i  = '0;
    bus.req_last_i  = '0;
    bus.out_ready_i = 1'b0;
    for (int i = 0; i < N; i++) begin
      left_beats[i] = 0;
      wait_pk[i]    = 0;
    end

    // Reset with everyone requesting, then release.
    for (int i = 0; i < N; i++) drive(i, 1'b1, 8'h10 + 8'(i), 1'b1);
    bus.out_ready_i = 1'b1;
    tick();
    chk("t1_rst_valid", 32'(s_valid), 0);
    chk("t1_rst_busy", 32'(s_busy), 0);
    rst = 1'b0;
    tick();
    chk("t1_first_src", 32'(s_src), 0);
    chk("t1_first_hs", 32'(s_hs), 1);

    // Single-beat fairness rotation.
    for (int n = 1; n <= 4; n++) begin
      tick();
      chk("t2_src", 32'(s_src), 32'(n % 4));
      chk("t2_hs", 32'(s_hs), 1);
      chk("t2_busy", 32'(s_busy), 0);
    end

    // Packet lock on req1 while req0 arrives mid-packet.
    for (int i = 0; i < N; i++) drive(i, 1'b0, 8'h00, 1'b0);
    drive(1, 1'b1, 8'hA1, 1'b0);
    tick();
    chk("t3_b1_src", 32'(s_src), 1);
    drive(1, 1'b1, 8'hA2, 1'b0);
    drive(0, 1'b1, 8'hB0, 1'b1);
    tick();
    chk("t3_b2_src", 32'(s_src), 1);
    chk("t3_b2_rdy0", 32'(s_ready[0]), 0);
    drive(1, 1'b1, 8'hA3, 1'b1);
    tick();
    chk("t3_b3_src", 32'(s_src), 1);
    chk("t3_b3_data", 32'(s_data), 32'h0A3);
    chk("t3_b3_rdy0", 32'(s_ready[0]), 0);
    drive(1, 1'b0, 8'h00, 1'b0);
    tick();
    chk("t3_next_src", 32'(s_src), 0);
    chk("t3_next_hs", 32'(s_hs), 1);
    drive(0, 1'b0, 8'h00, 1'b0);

    // Backpressure on a single-beat req2 packet while req0 waits.
    bus.out_ready_i = 1'b0;
    drive(2, 1'b1, 8'hC0, 1'b1);
    drive(0, 1'b1, 8'hD0, 1'b1);
    for (int n = 0; n < 5; n++) begin
      tick();
      chk("t4_src", 32'(s_src), 2);
      chk("t4_data", 32'(s_data), 32'h0C0);
      if (n > 0) chk("t4_busy", 32'(s_busy), 1);
    end
    bus.out_ready_i = 1'b1;
    tick();
    chk("t4_hs", 32'(s_hs), 1);
    chk("t4_hs_src", 32'(s_src), 2);
    drive(2, 1'b0, 8'h00, 1'b0);

    // ptr now 3: req3 outranks the waiting req0, then bubbles mid-packet.
    drive(3, 1'b1, 8'hE0, 1'b0);
    tick();
    chk("t5_src", 32'(s_src), 3);
    chk("t5_busy_pre", 32'(s_busy), 0);
    drive(3, 1'b0, 8'h00, 1'b0);
    for (int n = 0; n < 2; n++) begin
      tick();
      chk("t5_bub_valid", 32'(s_valid), 0);
      chk("t5_bub_busy", 32'(s_busy), 1);
      chk("t5_bub_rdy0", 32'(s_ready[0]), 0);
    end
    drive(3, 1'b1, 8'hE1, 1'b1);
    tick();
    chk("t5_last_src", 32'(s_src), 3);
    chk("t5_last_hs", 32'(s_hs), 1);
    drive(3, 1'b0, 8'h00, 1'b0);
    tick();
    chk("t5_wrap_src", 32'(s_src), 0);
    chk("t5_wrap_hs", 32'(s_hs), 1);
    drive(0, 1'b0, 8'h00, 1'b0);

    // Reset while locked on req2 abandons the packet and restarts priority at 0.
    bus.out_ready_i = 1'b0;
    drive(2, 1'b1, 8'hF0, 1'b0);
    tick();
    tick();
    chk("t6_locked_busy", 32'(s_busy), 1);
    chk("t6_locked_src", 32'(s_src), 2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(0, 1'b1, 8'h60, 1'b1);
    tick();
    chk("t6_after_src", 32'(s_src), 0);
    bus.out_ready_i = 1'b1;
    tick();
    chk("t6_after_hs", 32'(s_hs), 1);
    for (int i = 0; i < N; i++) drive(i, 1'b0, 8'h00, 1'b0);
    tick();

    // Randomized traffic with per-source scoreboard.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      bus.out_ready_i = ($urandom_range(0, 9) < 7);
      for (int i = 0; i < N; i++) begin
        if (!bus.req_valid_i[i] && $urandom_range(0, 9) < 5) begin
          if (left_beats[i] == 0) left_beats[i] = $urandom_range(1, 4);
          d = DW'($urandom);
          l = (left_beats[i] == 1);
          left_beats[i]--;
          drive(i, 1'b1, d, l);
          sbq[i].push_back({l, d});
        end
      end
      tick();
      if (s_hs) begin
        exp_beat = sbq[s_src].pop_front();
        chk("rnd_beat", 32'({s_last, s_data}), 32'(exp_beat));
        if (open_src >= 0) chk("rnd_interleave", 32'(s_src), 32'(open_src));
        open_src = s_last ? -1 : s_src;
        wait_pk[s_src] = 0;
        if (s_last) begin
          for (int i = 0; i < N; i++) begin
            if (i != s_src && bus.req_valid_i[i]) begin
              wait_pk[i]++;
              chk("rnd_starve", (wait_pk[i] <= N - 1) ? 1 : 0, 1);
            end
          end
        end
        bus.req_valid_i[s_src] = 1'b0;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
